// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default geometry, the main-decoder
// opcode field and the NOP word shown when the queue is empty.
package fetch_queue_pkg;

  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam int FQ_XLEN_DEFAULT  = 32;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int OP_W  = OP_HI - OP_LO + 1;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [OP_W-1:0] op_field(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are left unreset.
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer with
// wrap-bit pointers, registered occupancy and a flush for redirects.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int XLEN  = FQ_XLEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_instr,
  input  logic [XLEN-1:0]          enq_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_instr,
  output logic [XLEN-1:0]          deq_pc,
  output logic [OP_W-1:0]          deq_op,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  // Handshake: a transfer happens on a rising edge where valid && ready is
  // high (and flush is low); valid never waits on ready, and enq_ready is
  // purely !full so it does not depend on deq_ready.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW-1:0]       count_q;
  logic                empty;
  logic                full;
  logic                bypass;
  logic                enq_fire;
  logic                deq_fire;
  logic [2*XLEN-1:0]   wr_data;
  logic [2*XLEN-1:0]   rd_data;

  // Equal index bits with differing wrap bits means every slot is in use.
  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && enq_valid && !flush && !reset;
`endif
  end

  // A bypassed word consumed in the same cycle never touches storage.
  assign enq_fire = enq_valid && !full && !flush && !(bypass && deq_ready);
  assign deq_fire = !empty && deq_ready && !flush;

  assign wr_data = {enq_pc, enq_instr};

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (tail[AW-1:0]),
    .wdata (wr_data),
    .raddr (head[AW-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + PW'(1);
      end
      if (deq_fire) begin
        head <= head + PW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign enq_ready = !full;
  assign count     = count_q;

  always_comb begin
    deq_valid = !empty || bypass;
    deq_instr = XLEN'(NOP);
    deq_pc    = '0;
    if (bypass) begin
      deq_instr = enq_instr;
      deq_pc    = enq_pc;
    end else if (!empty) begin
      deq_instr = rd_data[XLEN-1:0];
      deq_pc    = rd_data[2*XLEN-1:XLEN];
    end
  end

  // The opcode field sits at fixed bits, so XLEN must be at least 32.
  assign deq_op = op_field(deq_instr[31:0]);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, full+simultaneous events, flush,
// pointer wrap, asynchronous mid-stream reset and the empty-queue bypass.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_instr;
  logic [XLEN-1:0] enq_pc;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_instr;
  logic [XLEN-1:0] deq_pc;
  logic [5:0]      deq_op;
  logic            flush;
  logic [CW-1:0]   count;

  int total = 0;
  int bad   = 0;

  logic [2*XLEN-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_instr (enq_instr),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .deq_op    (deq_op),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] ins, input logic [31:0] pc,
                       input logic dr, input logic fl);
    enq_valid = ev;
    enq_instr = ins;
    enq_pc    = pc;
    deq_ready = dr;
    flush     = fl;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int mc;
    int cyc;
    logic acc_enq;
    logic acc_deq;
    logic [2*XLEN-1:0] exp_e;

    // Reset state
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rst_count", count, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_deq_instr", deq_instr, 0);
    check("rst_deq_op", deq_op, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill with deq_ready low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h2008_0001 + i, 32'(4 * i), 1'b0, 1'b0);
      #1;
      if (i == 0) begin
`ifdef FETCH_QUEUE_BYPASS_EN
        check("fill_first_bypass_valid", deq_valid, 1);
`else
        check("fill_first_no_comb_valid", deq_valid, 0);
`endif
      end
      after_edge();
      check("fill_count", count, i + 1);
    end
    check("fill_enq_ready", enq_ready, 0);
    check("fill_deq_op", deq_op, 6'b001000);
    check("fill_deq_pc", deq_pc, 32'h0);
    check("fill_deq_instr", deq_instr, 32'h2008_0001);

    // Full with enqueue and dequeue in the same cycle
    @(negedge clk);
    drive(1'b1, 32'hDEAD_0001, 32'h0000_0F00, 1'b1, 1'b0);
    #1;
    check("full_enq_ready", enq_ready, 0);
    check("full_deq_valid", deq_valid, 1);
    after_edge();
    check("full_sim_count", count, 3);
    check("full_sim_head_pc", deq_pc, 32'h4);
    check("full_sim_head_instr", deq_instr, 32'h2008_0002);

    // Flush with a concurrent enqueue that must be dropped
    @(negedge clk);
    drive(1'b1, 32'h3C00_BEEF, 32'h0000_0999, 1'b0, 1'b1);
    after_edge();
    check("flush_count", count, 0);
    check("flush_deq_valid", deq_valid, 0);
    check("flush_enq_ready", enq_ready, 1);
    check("flush_deq_instr", deq_instr, 0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("flush_dropped_absent", deq_valid, 0);
    drive(1'b1, 32'h2400_0055, 32'h0000_0100, 1'b0, 1'b0);
    after_edge();
    check("post_flush_instr", deq_instr, 32'h2400_0055);
    check("post_flush_pc", deq_pc, 32'h100);
    check("post_flush_count", count, 1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    after_edge();
    check("post_flush_drain", count, 0);

    // Wrap: ten enqueues interleaved with dequeues, checked against exp_q
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    exp_q.delete();
    sent = 0;
    mc   = 0;
    cyc  = 0;
    while ((sent < 10 || mc > 0) && cyc < 60) begin
      @(negedge clk);
      drive(sent < 10, 32'h1000_0000 + 32'(sent), 32'h300 + 32'(4 * sent),
            (mc > 0) && (cyc % 3 != 0), 1'b0);
      #1;
      check("wrap_enq_ready", enq_ready, mc < DEPTH);
      acc_enq = enq_valid && (mc < DEPTH);
      acc_deq = deq_ready && (mc > 0);
      if (acc_deq) begin
        exp_e = exp_q.pop_front();
        check("wrap_order_instr", deq_instr, exp_e[XLEN-1:0]);
        check("wrap_order_pc", deq_pc, exp_e[2*XLEN-1:XLEN]);
      end
      if (acc_enq) begin
        exp_q.push_back({enq_pc, enq_instr});
        sent++;
      end
      after_edge();
      mc = mc + int'(acc_enq) - int'(acc_deq);
      check("wrap_count", count, mc);
      check("wrap_count_le_depth", count <= DEPTH, 1);
      cyc++;
    end
    check("wrap_budget", cyc < 60, 1);
    check("wrap_all_sent", sent, 10);
    check("wrap_queue_drained", exp_q.size(), 0);

    // Asynchronous reset between clock edges with two entries held
    @(negedge clk);
    drive(1'b1, 32'h1400_0001, 32'h500, 1'b0, 1'b0);
    after_edge();
    @(negedge clk);
    drive(1'b1, 32'h1400_0002, 32'h504, 1'b0, 1'b0);
    after_edge();
    check("midrst_pre_count", count, 2);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_deq_valid", deq_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_enq_ready", enq_ready, 1);
    check("midrst_deq_instr", deq_instr, 0);
    check("midrst_deq_pc", deq_pc, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h0C00_0010, 32'h0000_0040, 1'b0, 1'b0);
    after_edge();
    check("postrst_count", count, 1);
    check("postrst_deq_op", deq_op, 6'b000011);
    check("postrst_deq_pc", deq_pc, 32'h40);
    check("postrst_deq_instr", deq_instr, 32'h0C00_0010);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    after_edge();
    check("postrst_drain_count", count, 0);
    check("postrst_drain_valid", deq_valid, 0);

    // Empty queue, enqueue and dequeue offered together
    @(negedge clk);
    drive(1'b1, 32'h0800_0077, 32'h0000_0200, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("bypass_same_cycle_valid", deq_valid, 1);
    check("bypass_same_cycle_instr", deq_instr, 32'h0800_0077);
    check("bypass_same_cycle_pc", deq_pc, 32'h200);
    after_edge();
    check("bypass_count_stays_0", count, 0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("bypass_not_stored", deq_valid, 0);
`else
    check("nobypass_same_cycle_valid", deq_valid, 0);
    check("nobypass_same_cycle_instr", deq_instr, 0);
    after_edge();
    check("nobypass_count", count, 1);
    check("nobypass_next_valid", deq_valid, 1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("nobypass_next_instr", deq_instr, 32'h0800_0077);
    after_edge();
    check("nobypass_drain_count", count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, number of entries (power of two, 2..16); XLEN, default 32, instruction/PC width.
REQ-002 Ports SHALL be, one per line, with clock and reset first:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- enq_valid  input  1  fetch offers an instruction.
- enq_ready  output  1  queue accepts it.
- enq_instr  input  XLEN  instruction word.
- enq_pc  input  XLEN  instruction address.
- deq_valid  output  1  decode-side entry present.
- deq_ready  input  1  decode consumes the entry.
- deq_instr  output  XLEN  head instruction.
- deq_pc  output  XLEN  head PC.
- deq_op  output  6  deq_instr[31:26], the main-decoder opcode.
- flush  input  1  branch/jump redirect; discard all entries.
- count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-003 Storage SHALL be a circular buffer with head/tail pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-004 Empty SHALL be head==tail; full SHALL be equal index bits with differing wrap bits.
REQ-005 enq_ready SHALL be !full and SHALL NOT depend on deq_ready; when full, enqueue is refused even if a dequeue occurs in the same cycle.
REQ-006 An enqueue SHALL occur when enq_valid && enq_ready && !flush: write at tail, tail+1 with natural wrap.
REQ-007 A dequeue SHALL occur when deq_valid && deq_ready && !flush: head+1 with natural wrap.
REQ-008 A simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-009 deq_valid SHALL be !empty; deq_instr/deq_pc SHALL show the head entry, or 0 (NOP) when empty.
REQ-010 A write SHALL be visible at deq_* no earlier than the cycle after its enqueue, except as REQ-016 allows.
REQ-011 flush SHALL have priority over both enqueue and dequeue; that cycle's enq data is dropped.
REQ-012 After flush, head=tail=0, count=0 and deq_valid=0 from the next cycle.
REQ-013 count SHALL be registered; it SHALL never exceed DEPTH nor underflow.

Reset
REQ-014 Asserting reset SHALL immediately force head=tail=0, count=0, deq_valid=0, deq_instr=0, deq_pc=0, deq_op=0 and enq_ready=1, including mid-operation.
REQ-015 Storage contents SHALL need no reset.

Configuration
REQ-016 With FETCH_QUEUE_BYPASS_EN defined: when empty and enq_valid=1 and flush=0, deq_valid=1 and deq_* SHALL equal enq_* combinationally in the same cycle. If deq_ready=1 that cycle, the entry SHALL NOT be written and count stays 0; otherwise it is enqueued normally.
REQ-017 Without FETCH_QUEUE_BYPASS_EN, minimum enqueue-to-deq_valid latency SHALL be 1 cycle and no enq->deq combinational path SHALL exist.

Structure
REQ-018 The shared package SHALL hold the default DEPTH/XLEN constants, the opcode field bounds (31:26) and the NOP constant 32'h0.
REQ-019 One sub-module, fetch_queue_ram (DEPTH x 2*XLEN, one write port, one async read port), SHALL hold storage; pointer and count logic stays in fetch_queue.

Verification
REQ-020 Fill: reset, enqueue 4 words 0x20080001.. with PCs 0x0,0x4,0x8,0xC and deq_ready=0 -> count=4, enq_ready=0, deq_op=6'b001000, deq_pc=0x0.
REQ-021 Wrap: with DEPTH=4, run 10 enqueues interleaved with dequeues -> output order equals input order across pointer wrap; count never exceeds 4.
REQ-022 Full with simultaneous events: full queue, enq_valid=1 and deq_ready=1 -> one dequeue, no enqueue, count=3 next cycle.
REQ-023 Flush: count=3, then flush=1 together with enq_valid=1 -> count=0 and deq_valid=0 next cycle; the dropped word never appears at the output.
REQ-024 Reset mid-stream: count=2, assert reset between clock edges -> deq_valid=0, count=0 without waiting for a clock edge; the first post-reset enqueue (0x0C000010, pc 0x40) appears with deq_op=6'b000011.
REQ-025 Bypass: empty queue, enq_valid=1 and deq_ready=1 -> with FETCH_QUEUE_BYPASS_EN, deq_valid=1 in the same cycle and count stays 0; without it, deq_valid=1 one cycle later.
